io_display_out: RTL
===================

Name: io_display_out

Overview:
- Output-side IO peripheral: the transmit end of the CPU IO path.
- Takes the 32-bit word the CPU drives toward IO and shows it on an 8-digit multiplexed 7-segment display as hexadecimal; also drives 16 LEDs.
- CPU writes land in a shadow register. They are committed to the visible register only at a scan-frame boundary, so the display never shows a torn value.
- Sits beside the CPU top and is fed by the CPU's IO data output and its IO-write strobe.

Parameters:
- DIG_DIV, 50000, clk cycles each digit stays lit; legal range ≥ 2.
- CNT_W, 16, prescaler width; must satisfy 2^CNT_W ≥ DIG_DIV.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- wr_en_i  in  1  one-cycle IO-write strobe from the CPU.
- wdata_i  in  32  word to display, sampled when wr_en_i=1.
- an_o  out  8  digit enables, active-low; an_o[k] selects digit k; digit 0 is rightmost.
- seg_o  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}; dp is always off (1).
- led_o  out  16  display_q[15:0], registered.
- pending_o  out  1  high while a written value is waiting for a frame commit.

Behaviour:
- Reset (async, rst=1): all of the following take their values immediately.
  - an_o=8'hFF, seg_o=8'hFF, led_o=0, pending_o=0.
  - shadow_q=0, display_q=0, prescaler=0, idx=0.
- Prescaler counts 0..DIG_DIV-1. At DIG_DIV-1 it wraps to 0 and idx advances (7 wraps to 0). One frame = 8*DIG_DIV cycles.
- Commit point: the cycle where prescaler=DIG_DIV-1 and idx=7.
- Write, no commit in the same cycle: shadow_q<=wdata_i, pending<=1.
- Write while already pending: shadow_q is overwritten; the last write wins; pending stays 1.
- Commit with pending=1 and no write: display_q<=shadow_q, pending<=0.
- Commit coinciding with a write: display_q<=wdata_i, shadow_q<=wdata_i, pending stays 0. The new data wins and no extra frame delay is added.
- Commit with pending=0: display_q is unchanged.
- Outputs are registered from idx and display_q, so an_o, seg_o and led_o lag them by one clk.
  - an_o = ~(1<<idx).
  - seg_o = {1'b1, hex7(display_q[4*idx+3 -: 4])}.
  - led_o = display_q[15:0].
- hex7 (active-low {g..a}): 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10, A→7'h08, b→7'h03, C→7'h46, d→7'h21, E→7'h06, F→7'h0E.
- Reset asserted mid-frame discards any pending write. After rst deasserts:
  - the first an_o=8'hFE appears on the first clk edge;
  - digit 0 dwells DIG_DIV cycles.

Optional Feature:
- Macro: IO_DISPLAY_LZB_EN.
- Defined: leading-zero blanking, decided per digit from display_q.
  - Any digit k>0 whose nibble and all higher nibbles are zero is blanked: an_o=8'hFF and seg_o=8'hFF during its slot.
  - Digit 0 is never blanked.
  - Slot timing and commit point are unchanged.
- Undefined: all 8 digits are always shown, including leading zeros.

Test Plan:
- Reset check (DIG_DIV=4): assert rst mid-scan → an_o=FF, seg_o=FF, led_o=0, pending_o=0 immediately. After release, an_o cycles FE,FD,…,7F, each for 4 cycles.
- Single write (DIG_DIV=4): wr 32'h1234ABCD at idx=2.
  - pending_o=1 until the commit.
  - At the commit, led_o becomes 16'hABCD one cycle after display_q updates.
  - Next frame: digit0 seg=8'hA1 (d), digit7 seg=8'hF9 (1).
- Back-to-back writes: wr 32'h11111111 then 32'h0000000F within one frame → after commit the display shows 0000000F; digit0 seg=8'h8E; 32'h11111111 never appears.
- Write exactly at the commit cycle: wr 32'h88888888 → pending_o stays 0; the following frame shows seg=8'h80 on all digits.
- Frame-integrity check: issue 50 random writes at random cycles. The scoreboard checks that the value reconstructed from the 8 digit slots of every complete frame equals one single committed value.
- With IO_DISPLAY_LZB_EN defined: write 32'h000000A0 → digits 0–1 shown (seg 8'hC0, 8'h88); digits 2–7 blanked (an_o=FF during their slots).
  - Write 0 → only digit 0 is lit, showing seg=8'hC0.

Source files
------------

// File: rtl/io_display_out_if.sv
// CPU-to-display write channel: the IO-write strobe, its data word and the
// commit-pending status returned to the CPU side.
interface io_display_out_if;
  // Handshake: wr_en_i is a one-cycle valid strobe with no ready. Every strobe
  // is accepted on the clk edge where it is high, and wdata_i is sampled on
  // that edge. pending_o is high from the edge after an accepted word until
  // the frame commit that makes it visible.
  logic        wr_en_i;
  logic [31:0] wdata_i;
  logic        pending_o;

  modport master (output wr_en_i, output wdata_i, input pending_o);
  modport slave  (input wr_en_i, input wdata_i, output pending_o);
endinterface

// File: rtl/io_display_out.sv
// 8-digit multiplexed hex display with a shadow register that is committed only
// at a scan-frame boundary. Optional macro IO_DISPLAY_LZB_EN enables leading-zero blanking.
module io_display_out #(
  parameter int DIG_DIV = 50000,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  io_display_out_if.slave   bus,
  output logic [7:0]        an_o,
  output logic [7:0]        seg_o,
  output logic [15:0]       led_o
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIG_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      display_q, display_d;
  logic             pending_q, pending_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic [15:0]      led_q, led_d;

  logic             slot_end;
  logic             commit;
  logic [4:0]       shamt;
  logic [3:0]       nib;
  logic             blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign slot_end = (presc_q == DIV_LAST);
  assign commit   = slot_end && (idx_q == 3'd7);

  always_comb begin
    presc_d   = presc_q + CNT_ONE;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    display_d = display_q;
    pending_d = pending_q;

    if (slot_end) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end

    // A write landing on the commit cycle goes straight to the display so the
    // newest value is never held back a whole extra frame.
    if (commit) begin
      if (bus.wr_en_i) begin
        shadow_d  = bus.wdata_i;
        display_d = bus.wdata_i;
      end else if (pending_q) begin
        display_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (bus.wr_en_i) begin
      shadow_d  = bus.wdata_i;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    shamt = {idx_q, 2'b00};
    nib   = display_q[shamt +: 4];
    blank = 1'b0;
`ifdef IO_DISPLAY_LZB_EN
    // Blank digit k>0 when it and every nibble above it are zero.
    blank = (idx_q != 3'd0) && ((display_q >> shamt) == 32'd0);
`endif
    an_d  = blank ? 8'hFF : ~(8'h01 << idx_q);
    seg_d = blank ? 8'hFF : {1'b1, hex7(nib)};
    led_d = display_q[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      idx_q     <= 3'd0;
      shadow_q  <= 32'd0;
      display_q <= 32'd0;
      pending_q <= 1'b0;
      an_q      <= 8'hFF;
      seg_q     <= 8'hFF;
      led_q     <= 16'd0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      led_q     <= led_d;
    end
  end

  assign an_o          = an_q;
  assign seg_o         = seg_q;
  assign led_o         = led_q;
  assign bus.pending_o = pending_q;

endmodule
